// File: rtl/pedal_pkg.sv
// Shared types and constants for the pedal mode controller.
// The fade sequencing is built only when PEDAL_MODE_CTRL_FADE_EN is defined.
package pedal_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    APPLY    = 2'd2,
    FADE_IN  = 2'd3
  } pedal_state_e;

  localparam logic [4:0] FADE_UNITY = 5'd16;

  localparam logic [3:0] OPT_WEAK_OD   = 4'b1000;
  localparam logic [3:0] OPT_STRONG_OD = 4'b0100;
  localparam logic [3:0] OPT_OD        = 4'b0010;
  localparam logic [3:0] OPT_DIST      = 4'b0001;

  function automatic logic [3:0] opt_for_idx(input logic [1:0] idx);
    logic [3:0] opt;
    case (idx)
      2'd0:    opt = OPT_WEAK_OD;
      2'd1:    opt = OPT_STRONG_OD;
      2'd2:    opt = OPT_OD;
      default: opt = OPT_DIST;
    endcase
    return opt;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, and a one-cycle
// pulse on the accepted 0->1 edge. Used by both buttons of pedal_mode_ctrl.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 480
) (
  input  logic clk_48,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [1:0]    sync_q;
  logic          db_q;
  logic [CW-1:0] cnt_q;

  // The counter runs only while the synced level disagrees with the accepted
  // level; any agreeing sample restarts the stability window.
  always_ff @(posedge clk_48) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      db_q   <= 1'b0;
      cnt_q  <= '0;
      press  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
      press  <= 1'b0;
      if (sync_q[1] != db_q) begin
        if (cnt_q == CNT_LAST) begin
          db_q  <= sync_q[1];
          cnt_q <= '0;
          press <= sync_q[1];
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/pedal_mode_ctrl.sv
// Mode/bypass controller for the distortion datapath with click-free fades.
// Define PEDAL_MODE_CTRL_FADE_EN to build the FADE_OUT/FADE_IN sequencing.
module pedal_mode_ctrl
  import pedal_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = 480,
  parameter int FADE_STEP_CYC = 48
) (
  input  logic         clk_48,
  input  logic         rst_n,
  input  logic         btn_mode,
  input  logic         btn_bypass,
  output logic [3:0]   options,
  output logic [3:0]   en,
  output logic [4:0]   fade_lvl,
  output logic [1:0]   mode_idx,
  output logic         busy,
  output pedal_state_e state_dbg
);

  // Handshake: none. Button events are single-cycle pulses, taken only in IDLE.
  logic mode_ev, bypass_ev;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mode (
    .clk_48(clk_48), .rst_n(rst_n), .btn_raw(btn_mode), .press(mode_ev)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_bypass (
    .clk_48(clk_48), .rst_n(rst_n), .btn_raw(btn_bypass), .press(bypass_ev)
  );

  pedal_state_e state_q, state_d;
  logic         pend_bypass_q, pend_bypass_d;
  logic         en0_q, en0_d;
  logic [1:0]   idx_d;
  logic [4:0]   fade_d;
  logic         busy_d;

`ifdef PEDAL_MODE_CTRL_FADE_EN
  localparam int SW = (FADE_STEP_CYC < 2) ? 1 : $clog2(FADE_STEP_CYC);
  localparam logic [SW-1:0] STEP_LAST = SW'(FADE_STEP_CYC - 1);
  localparam pedal_state_e  FIRST_ST  = FADE_OUT;
  logic [SW-1:0] step_q, step_d;
`else
  localparam pedal_state_e  FIRST_ST  = APPLY;
`endif

  assign en        = {3'b000, en0_q};
  assign state_dbg = state_q;

  always_comb begin
    state_d       = state_q;
    pend_bypass_d = pend_bypass_q;
    en0_d         = en0_q;
    idx_d         = mode_idx;
    fade_d        = fade_lvl;
    busy_d        = busy;
`ifdef PEDAL_MODE_CTRL_FADE_EN
    step_d        = step_q;
`endif
    case (state_q)
      IDLE: begin
        // Bypass wins a tie; a mode change with the effect off needs no fade.
        if (bypass_ev || (mode_ev && en0_q)) begin
          pend_bypass_d = bypass_ev;
          state_d       = FIRST_ST;
          busy_d        = 1'b1;
`ifdef PEDAL_MODE_CTRL_FADE_EN
          step_d        = '0;
`endif
        end else if (mode_ev) begin
          idx_d = mode_idx + 2'd1;
        end
      end
`ifdef PEDAL_MODE_CTRL_FADE_EN
      FADE_OUT: begin
        if (fade_lvl == 5'd0) begin
          state_d = APPLY;
        end else if (step_q == STEP_LAST) begin
          step_d = '0;
          fade_d = fade_lvl - 5'd1;
        end else begin
          step_d = step_q + SW'(1);
        end
      end
      FADE_IN: begin
        if (fade_lvl == FADE_UNITY) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (step_q == STEP_LAST) begin
          step_d = '0;
          fade_d = fade_lvl + 5'd1;
        end else begin
          step_d = step_q + SW'(1);
        end
      end
`endif
      APPLY: begin
        if (pend_bypass_q) en0_d = ~en0_q;
        else               idx_d = mode_idx + 2'd1;
`ifdef PEDAL_MODE_CTRL_FADE_EN
        state_d = FADE_IN;
        step_d  = '0;
`else
        state_d = IDLE;
        busy_d  = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_48) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pend_bypass_q <= 1'b0;
      en0_q         <= 1'b0;
      mode_idx      <= 2'd0;
      options       <= OPT_WEAK_OD;
      fade_lvl      <= FADE_UNITY;
      busy          <= 1'b0;
`ifdef PEDAL_MODE_CTRL_FADE_EN
      step_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pend_bypass_q <= pend_bypass_d;
      en0_q         <= en0_d;
      mode_idx      <= idx_d;
      options       <= opt_for_idx(idx_d);
      fade_lvl      <= fade_d;
      busy          <= busy_d;
`ifdef PEDAL_MODE_CTRL_FADE_EN
      step_q        <= step_d;
`endif
    end
  end

endmodule

// File: doc/pedal_mode_ctrl.md
PEDAL_MODE_CTRL -- requirements
Module: pedal_mode_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, default 480, stable cycles required to accept a button level change (10 ms at 48 kHz).
REQ-002 SHALL have parameter FADE_STEP_CYC, default 48, cycles per fade level step.
REQ-003 SHALL have port clk_48  input  1  single clock, one cycle per audio sample; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port btn_mode  input  1  raw, asynchronous, active-high mode-advance button.
REQ-006 SHALL have port btn_bypass  input  1  raw, asynchronous, active-high effect on/off button.
REQ-007 SHALL have port options  output  4  one-hot mode select to the distortion datapath.
REQ-008 SHALL have port en  output  4  enable to the distortion datapath; en[3:1] is constant 0.
REQ-009 SHALL have port fade_lvl  output  5  output gain, 0..16; 16 = unity, 0 = mute.
REQ-010 SHALL have port mode_idx  output  2  current mode index, for status LEDs.
REQ-011 SHALL have port busy  output  1  high while a fade or apply is in progress.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer and then a debouncer; the debounced state updates only after DEBOUNCE_CYC consecutive equal synced samples.
REQ-013 A press event SHALL be a 1-cycle pulse on the debounced 0->1 edge; a held button produces exactly one event.
REQ-014 options SHALL equal 4'b1000 >> mode_idx: idx 0 = weak overdrive, 1 = strong overdrive, 2 = overdrive, 3 = distortion.
REQ-015 A mode advance SHALL increment mode_idx modulo 4, so 3 wraps to 0.
REQ-016 The FSM SHALL have states IDLE, FADE_OUT, APPLY and FADE_IN; only IDLE accepts events.
REQ-017 In IDLE, a bypass event, or a mode event while en[0]=1, SHALL latch the pending action, go to FADE_OUT and set busy=1 on the next cycle.
REQ-018 In FADE_OUT, fade_lvl SHALL decrement by 1 every FADE_STEP_CYC cycles; the FSM goes to APPLY in the cycle after fade_lvl reaches 0.
REQ-019 APPLY SHALL last 1 cycle: toggle en[0] (bypass) or advance mode_idx (mode), then go to FADE_IN.
REQ-020 In FADE_IN, fade_lvl SHALL increment by 1 every FADE_STEP_CYC cycles; the cycle after fade_lvl reaches 16, the FSM goes to IDLE and busy is set to 0.
REQ-021 A mode event in IDLE while en[0]=0 SHALL advance mode_idx on the next cycle with no fade; busy and fade_lvl are unchanged.
REQ-022 Simultaneous bypass and mode events SHALL act on bypass only; the mode event is discarded.
REQ-023 Events arriving while busy=1 SHALL be discarded, not queued.
REQ-024 All outputs SHALL be registered; options, en and mode_idx change only in APPLY or per REQ-021.

Reset
REQ-025 When rst_n=0 at a clk_48 edge, the block SHALL set mode_idx=0, options=4'b1000, en=4'b0000, fade_lvl=16, busy=0 and FSM=IDLE, and clear the synchronizers, debounce counters, debounced states and step counter.
REQ-026 Reset asserted mid-fade SHALL abort the fade; the pending action is lost.

Configuration
REQ-027 Macro PEDAL_MODE_CTRL_FADE_EN defined: the FSM SHALL behave as in REQ-016..REQ-020.
REQ-028 Macro PEDAL_MODE_CTRL_FADE_EN undefined: FADE_OUT and FADE_IN SHALL be omitted, so the sequence is IDLE->APPLY->IDLE; fade_lvl is constant 16 and busy is high only during APPLY.

Structure
REQ-029 The shared package pedal_pkg SHALL hold the FSM state typedef, FADE_UNITY=16, and the four options one-hot constants.
REQ-030 The debouncer SHALL be the sub-module btn_debounce (sync + counter + edge pulse), instantiated twice.

Verification (DEBOUNCE_CYC=4, FADE_STEP_CYC=2, fade enabled unless stated)
REQ-031 Release reset -> options=1000, en=0000, fade_lvl=16, busy=0, mode_idx=0.
REQ-032 Bypass press held 10 cycles -> busy=1; fade_lvl steps 16->0 over 32 cycles; en becomes 0001 in APPLY; fade_lvl returns to 16 over 32 cycles; busy=0; exactly one toggle.
REQ-033 With en=0000, four separate mode presses -> options 0100, 0010, 0001, 1000 in order; fade_lvl stays 16 and busy stays 0 throughout.
REQ-034 3-cycle glitch on btn_mode -> no event, all outputs unchanged; repeat with en=0001 and mode pressed during a fade -> press ignored.
REQ-035 btn_mode and btn_bypass rising in the same cycle -> en toggles, mode_idx unchanged.
REQ-036 rst_n low while fade_lvl=7 in FADE_OUT -> reset values on the next cycle; with the macro undefined, bypass press -> en toggles with fade_lvl fixed at 16 and busy high for 1 cycle.
